// File: rtl/template_matcher_if.sv
// Patch stream, template load and best-match result bundle for template_matcher.
interface template_matcher_if;
  logic                    tmpl_load;
  logic [15:0][15:0][7:0]  tmpl_data;
  logic [15:0][15:0][7:0]  window_data;
  logic                    window_ready;
  logic                    receive;
  logic [15:0]             best_sad;
  logic [6:0]              best_row;
  logic [6:0]              best_col;
  logic                    result_valid;
  logic                    busy;

  modport master (
    output tmpl_load, tmpl_data, window_data, window_ready,
    input  receive, best_sad, best_row, best_col, result_valid, busy
  );

  modport slave (
    input  tmpl_load, tmpl_data, window_data, window_ready,
    output receive, best_sad, best_row, best_col, result_valid, busy
  );
endinterface

// File: rtl/template_matcher.sv
// SAD template matcher: scores one 16x16 patch per cycle against a stored template
// and reports the minimum-SAD position once per NPOS x NPOS frame.
module template_matcher #(
  parameter int NPOS = 65
) (
  input  logic              clk,
  input  logic              rst_n,
  template_matcher_if.slave bus
);
  typedef logic [15:0][15:0][7:0] patch_t;
  localparam logic [6:0] LAST = 7'(NPOS - 1);

  function automatic logic [7:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
    logic signed [8:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return d[8] ? 8'(-d) : d[7:0];
  endfunction

  patch_t            tmpl_q;
  patch_t            win_p0;
  logic [6:0]        pos_row, pos_col;
  logic [6:0]        row_p0, col_p0, row_p1, col_p1, row_p2, col_p2;
  logic              vld_p0, vld_p1, vld_p2;
  logic [15:0][11:0] rowsum_c, rowsum_p1;
  logic [15:0]       sad_c, sad_p2;
  logic [15:0]       best_sad_q;
  logic [6:0]        best_row_q, best_col_q;
  logic              receive_q, result_valid_q, busy_q;
  logic              accept, tmpl_we, first_p2, last_p2, more_work;

  assign accept   = bus.window_ready;
  assign tmpl_we  = bus.tmpl_load && !busy_q;
  assign first_p2 = (row_p2 == 7'd0) && (col_p2 == 7'd0);
  assign last_p2  = vld_p2 && (row_p2 == LAST) && (col_p2 == LAST);
  // Anything accepted after the final patch belongs to the next frame and keeps busy up.
  assign more_work = accept || vld_p0 || vld_p1 || (pos_row != 7'd0) || (pos_col != 7'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_row        <= '0;
      pos_col        <= '0;
      vld_p0         <= 1'b0;
      vld_p1         <= 1'b0;
      vld_p2         <= 1'b0;
      receive_q      <= 1'b0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      tmpl_q         <= '0;
      best_sad_q     <= 16'hFFFF;
      best_row_q     <= '0;
      best_col_q     <= '0;
    end else begin
      // S0: accept patch and advance raster tag
      vld_p0    <= accept;
      receive_q <= accept;
      if (accept) begin
        if (pos_col == LAST) begin
          pos_col <= '0;
          pos_row <= (pos_row == LAST) ? 7'd0 : pos_row + 7'd1;
        end else begin
          pos_col <= pos_col + 7'd1;
        end
      end
      if (tmpl_we)
        tmpl_q <= bus.tmpl_data;
      // S1/S2 valid tracking
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
      // S3: minimum update, (0,0) always reloads
      if (vld_p2 && (first_p2 || (sad_p2 < best_sad_q))) begin
        best_sad_q <= sad_p2;
        best_row_q <= row_p2;
        best_col_q <= col_p2;
      end
      result_valid_q <= last_p2;
      busy_q         <= more_work || (busy_q && !last_p2);
    end
  end

  always_comb begin
    rowsum_c = '0;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        rowsum_c[r] = rowsum_c[r] + 12'(abs_diff(win_p0[r][c], tmpl_q[r][c]));
  end

  always_comb begin
    sad_c = '0;
    for (int r = 0; r < 16; r++)
      sad_c = sad_c + 16'(rowsum_p1[r]);
  end

  always_ff @(posedge clk) begin
    // S0 data
    if (accept) begin
      win_p0 <= bus.window_data;
      row_p0 <= pos_row;
      col_p0 <= pos_col;
    end
    // S1 data: per-row SAD
    rowsum_p1 <= rowsum_c;
    row_p1    <= row_p0;
    col_p1    <= col_p0;
    // S2 data: patch SAD
    sad_p2 <= sad_c;
    row_p2 <= row_p1;
    col_p2 <= col_p1;
  end

  assign bus.receive      = receive_q;
  assign bus.result_valid = result_valid_q;
  assign bus.busy         = busy_q;
  assign bus.best_sad     = best_sad_q;
  assign bus.best_row     = best_row_q;
  assign bus.best_col     = best_col_q;
endmodule
